// File: rtl/otter_mmio_pkg.sv
// otter_mmio_pkg: shared definitions for the OTTER MMIO hub.
//  - Register offsets within the 256-byte MMIO window.
//  - Bit positions of the CTRL register fields.
package otter_mmio_pkg;

    localparam logic [7:0] OFS_SW     = 8'h00;
    localparam logic [7:0] OFS_BTN    = 8'h04;
    localparam logic [7:0] OFS_LEDS   = 8'h08;
    localparam logic [7:0] OFS_SSEG   = 8'h0C;
    localparam logic [7:0] OFS_COUNT  = 8'h10;
    localparam logic [7:0] OFS_CMP    = 8'h14;
    localparam logic [7:0] OFS_CTRL   = 8'h18;
    localparam logic [7:0] OFS_STATUS = 8'h1C;

    localparam int unsigned CTRL_TEN    = 0;  // timer enable
    localparam int unsigned CTRL_TIE    = 1;  // timer interrupt enable
    localparam int unsigned CTRL_RELOAD = 2;  // clear COUNT on compare match
    localparam int unsigned CTRL_BIE    = 3;  // button interrupt enable
    localparam int unsigned CTRL_W      = 4;

endpackage

// File: rtl/otter_debounce.sv
// otter_debounce: one button input conditioner.
//  - 2-flop synchronizer on the raw pin.
//  - Counter that must see the synchronized level differ from the stable level for
//    DEBOUNCE_CYC consecutive cycles before the stable level follows it.
//  - rise_o pulses for one cycle, coincident with the stable level being updated 0->1.
// Ports:
//  clk_i    in   system clock
//  rst_i    in   synchronous active-high reset
//  btn_i    in   raw asynchronous button pin
//  level_o  out  debounced stable level
//  rise_o   out  single-cycle pulse on an accepted 0->1 transition
module otter_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic            meta_q, sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_o   = 1'b0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // Level has differed for DEBOUNCE_CYC cycles: accept it.
            stable_d = sync_q;
            cnt_d    = '0;
            rise_o   = sync_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// otter_mmio_hub: memory-mapped peripheral hub behind the OTTER memory MMIO port.
//  - Decodes a 256-byte window at BASE_ADDR; full-word writes on IO_WR.
//  - IO_IN is a zero-latency read mux of the addressed register.
//  - Switch synchronizer, per-button debounce, LED / seven-segment registers,
//    32-bit timer with compare, sticky STATUS (write-1-to-clear) and a level INTR.
// Ports:
//  CLK, RST            clock, synchronous active-high reset
//  IO_ADDR/IO_WR/IO_WD address, write strobe, write data from the memory block
//  IO_IN               combinational read data
//  SWITCHES, BUTTONS   raw asynchronous inputs
//  LEDS, SSEG          output registers
//  INTR                registered interrupt request
module otter_mmio_hub
    import otter_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
    parameter int unsigned N_SW         = 16,
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       IO_ADDR,
    input  logic              IO_WR,
    input  logic [31:0]       IO_WD,
    output logic [31:0]       IO_IN,
    input  logic [N_SW-1:0]   SWITCHES,
    input  logic [N_BTN-1:0]  BUTTONS,
    output logic [15:0]       LEDS,
    output logic [15:0]       SSEG,
    output logic              INTR
);

    logic              hit, we;
    logic [7:0]        offset;
    logic              match;

    logic [N_SW-1:0]   sw_meta_q, sw_sync_q;
    logic [N_BTN-1:0]  btn_level, btn_rise;

    logic [15:0]       leds_q, leds_d;
    logic [15:0]       sseg_q, sseg_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q, cmp_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [N_BTN:0]    status_q, status_d;  // bit0 TMF, bits[N_BTN:1] press pending
    logic              intr_q, intr_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        otter_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk_i  (CLK),
            .rst_i  (RST),
            .btn_i  (BUTTONS[i]),
            .level_o(btn_level[i]),
            .rise_o (btn_rise[i])
        );
    end

    always_comb begin
        hit    = (IO_ADDR[31:8] == BASE_ADDR[31:8]);
        offset = IO_ADDR[7:0];
        we     = IO_WR && hit;
    end

    // Register file and timer next state.
    always_comb begin
        leds_d   = leds_q;
        sseg_d   = sseg_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        status_d = status_q;

        match = ctrl_q[CTRL_TEN] && (count_q == cmp_q);

        if (ctrl_q[CTRL_TEN]) begin
            count_d = (match && ctrl_q[CTRL_RELOAD]) ? 32'd0 : count_q + 32'd1;
        end

        if (we) begin
            case (offset)
                OFS_LEDS:   leds_d   = IO_WD[15:0];
                OFS_SSEG:   sseg_d   = IO_WD[15:0];
                OFS_COUNT:  count_d  = IO_WD;
                OFS_CMP:    cmp_d    = IO_WD;
                OFS_CTRL:   ctrl_d   = IO_WD[CTRL_W-1:0];
                OFS_STATUS: status_d = status_q & ~IO_WD[N_BTN:0];
                default: ;
            endcase
        end

        // Set events are applied after the W1C so that a same-cycle set wins.
        status_d = status_d | {btn_rise, match};

        intr_d = (ctrl_q[CTRL_TIE] && status_q[0])
               || (ctrl_q[CTRL_BIE] && (|status_q[N_BTN:1]));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            leds_q    <= '0;
            sseg_q    <= '0;
            count_q   <= '0;
            cmp_q     <= 32'hFFFF_FFFF;
            ctrl_q    <= '0;
            status_q  <= '0;
            intr_q    <= 1'b0;
        end else begin
            sw_meta_q <= SWITCHES;
            sw_sync_q <= sw_meta_q;
            leds_q    <= leds_d;
            sseg_q    <= sseg_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            intr_q    <= intr_d;
        end
    end

    always_comb begin
        IO_IN = 32'd0;
        if (hit) begin
            case (offset)
                OFS_SW:     IO_IN = 32'(sw_sync_q);
                OFS_BTN:    IO_IN = 32'(btn_level);
                OFS_LEDS:   IO_IN = {16'd0, leds_q};
                OFS_SSEG:   IO_IN = {16'd0, sseg_q};
                OFS_COUNT:  IO_IN = count_q;
                OFS_CMP:    IO_IN = cmp_q;
                OFS_CTRL:   IO_IN = 32'(ctrl_q);
                OFS_STATUS: IO_IN = 32'(status_q);
                default:    IO_IN = 32'd0;
            endcase
        end
    end

    assign LEDS = leds_q;
    assign SSEG = sseg_q;
    assign INTR = intr_q;

endmodule
